// File: rtl/cpu_pkg.sv
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared constants and the next-PC select encoding used by the
//                instruction-fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    // Default program-counter / address width in bits.
    localparam int PC_W = 32;

    // Number of words in the instruction memory; PCs at or above this are out of range.
    localparam int IM_DEPTH = 64;

    // Instruction word inserted into IF/ID whenever a bubble is created.
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // Width of the absolute jump word index field.
    localparam int JT_W = 26;

    // Source of the next program counter.
    typedef enum logic [2:0] {
        SEQ  = 3'd0,   // PC + 1
        HOLD = 3'd1,   // stall: keep PC
        BR   = 3'd2,   // taken conditional branch
        J    = 3'd3,   // absolute jump
        JR   = 3'd4    // jump to register value
    } next_pc_sel_e;

endpackage : cpu_pkg

`default_nettype wire

// File: rtl/npc_sel.sv
// ============================================================================
//  Module      : npc_sel
//  Description : Combinational next-PC mux with priority encoder
//                (JR > J > BR > HOLD > SEQ). Redirects are honoured only
//                while IF/ID holds a valid instruction.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module npc_sel
    import cpu_pkg::*;
#(
    parameter int PC_W = cpu_pkg::PC_W
) (
    input  logic [PC_W-1:0] i_pc,
    input  logic [PC_W-1:0] i_ifid_pcplus1,
    input  logic            i_ifid_valid,
    input  logic            i_stall,
    input  logic            i_branch_taken,
    input  logic [15:0]     i_branch_offset,
    input  logic            i_jump,
    input  logic [JT_W-1:0] i_jump_target,
    input  logic            i_jump_reg,
    input  logic [PC_W-1:0] i_reg_target,
    output next_pc_sel_e    o_sel,
    output logic [PC_W-1:0] o_next_pc
);

    logic [PC_W-1:0] w_br_target;
    logic [PC_W-1:0] w_j_target;

    // Branch target: word offset sign-extended and added modulo 2^PC_W.
    assign w_br_target = i_ifid_pcplus1 + PC_W'($signed(i_branch_offset));

    // Jump target keeps the upper PC bits of the instruction being decoded.
    if (PC_W > JT_W) begin : g_jt_wide
        assign w_j_target = {i_ifid_pcplus1[PC_W-1:JT_W], i_jump_target};
    end else begin : g_jt_narrow
        assign w_j_target = i_jump_target[PC_W-1:0];
    end

    // Priority encoder and target mux; a bubble in IF/ID masks stale redirects.
    always_comb begin
        o_sel     = SEQ;
        o_next_pc = i_pc + PC_W'(1);
        if (i_ifid_valid && i_jump_reg) begin
            o_sel     = JR;
            o_next_pc = i_reg_target;
        end else if (i_ifid_valid && i_jump) begin
            o_sel     = J;
            o_next_pc = w_j_target;
        end else if (i_ifid_valid && i_branch_taken) begin
            o_sel     = BR;
            o_next_pc = w_br_target;
        end else if (i_stall) begin
            o_sel     = HOLD;
            o_next_pc = i_pc;
        end
    end

endmodule : npc_sel

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch stage. Owns the PC, drives the instruction
//                memory address and fills the IF/ID pipeline register;
//                applies redirects, stall and flush, and flags out-of-range
//                fetches with a sticky error.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
    import cpu_pkg::*;
#(
    parameter int              PC_W     = cpu_pkg::PC_W,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              IM_DEPTH = cpu_pkg::IM_DEPTH,
    parameter logic [31:0]     NOP_WORD = cpu_pkg::NOP_WORD
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [31:0]     IM,
    input  logic            Stall,
    input  logic            Flush,
    input  logic            BranchTaken,
    input  logic [15:0]     BranchOffset,
    input  logic            Jump,
    input  logic [25:0]     JumpTarget,
    input  logic            JumpReg,
    input  logic [PC_W-1:0] RegTarget,
    output logic [PC_W-1:0] PC,
    output logic [31:0]     IfId_Instr,
    output logic [PC_W-1:0] IfId_PcPlus1,
    output logic            IfId_Valid,
    output logic            AddrErr
);

    localparam logic [PC_W-1:0] c_IM_LIMIT = PC_W'(IM_DEPTH);

    logic [PC_W-1:0] r_pc;
    logic [31:0]     r_ifid_instr;
    logic [PC_W-1:0] r_ifid_pcplus1;
    logic            r_ifid_valid;
    logic            r_addr_err;

    next_pc_sel_e    w_sel;
    logic [PC_W-1:0] w_next_pc;
    logic [PC_W-1:0] w_pc_plus1;
    logic            w_redirect;

    assign w_pc_plus1 = r_pc + PC_W'(1);
    assign w_redirect = (w_sel == JR) || (w_sel == J) || (w_sel == BR);

    npc_sel #(
        .PC_W (PC_W)
    ) u_npc_sel (
        .i_pc            (r_pc),
        .i_ifid_pcplus1  (r_ifid_pcplus1),
        .i_ifid_valid    (r_ifid_valid),
        .i_stall         (Stall),
        .i_branch_taken  (BranchTaken),
        .i_branch_offset (BranchOffset),
        .i_jump          (Jump),
        .i_jump_target   (JumpTarget),
        .i_jump_reg      (JumpReg),
        .i_reg_target    (RegTarget),
        .o_sel           (w_sel),
        .o_next_pc       (w_next_pc)
    );

    // PC register: loads the selected next PC (hold is encoded in the mux).
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_next_pc;
        end
    end

    // IF/ID register: redirect or flush inserts a bubble, stall holds, else capture.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_ifid_instr   <= NOP_WORD;
            r_ifid_pcplus1 <= '0;
            r_ifid_valid   <= 1'b0;
        end else if (w_redirect || Flush) begin
            r_ifid_instr   <= NOP_WORD;
            r_ifid_pcplus1 <= '0;
            r_ifid_valid   <= 1'b0;
        end else if (w_sel != HOLD) begin
            r_ifid_instr   <= IM;
            r_ifid_pcplus1 <= w_pc_plus1;
            r_ifid_valid   <= 1'b1;
        end
    end

    // Sticky address error: any non-stalled edge that consumes an out-of-range PC.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_addr_err <= 1'b0;
        end else if ((w_sel != HOLD) && (r_pc >= c_IM_LIMIT)) begin
            r_addr_err <= 1'b1;
        end
    end

    assign PC           = r_pc;
    assign IfId_Instr   = r_ifid_instr;
    assign IfId_PcPlus1 = r_ifid_pcplus1;
    assign IfId_Valid   = r_ifid_valid;
    assign AddrErr      = r_addr_err;

endmodule : fetch_unit

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit using a table of directed
//                vectors plus hand-written reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    logic        Clk;
    logic        Reset;
    logic [31:0] IM;
    logic        Stall;
    logic        Flush;
    logic        BranchTaken;
    logic [15:0] BranchOffset;
    logic        Jump;
    logic [25:0] JumpTarget;
    logic        JumpReg;
    logic [31:0] RegTarget;
    logic [31:0] PC;
    logic [31:0] IfId_Instr;
    logic [31:0] IfId_PcPlus1;
    logic        IfId_Valid;
    logic        AddrErr;

    int n_checks;
    int n_fail;

    fetch_unit u_dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .IM           (IM),
        .Stall        (Stall),
        .Flush        (Flush),
        .BranchTaken  (BranchTaken),
        .BranchOffset (BranchOffset),
        .Jump         (Jump),
        .JumpTarget   (JumpTarget),
        .JumpReg      (JumpReg),
        .RegTarget    (RegTarget),
        .PC           (PC),
        .IfId_Instr   (IfId_Instr),
        .IfId_PcPlus1 (IfId_PcPlus1),
        .IfId_Valid   (IfId_Valid),
        .AddrErr      (AddrErr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Instruction memory contents: word 0 is a fixed instruction, others tag their address.
    function automatic logic [31:0] imem(input logic [31:0] a);
        if (a == 32'd0) return 32'h2001_0005;
        return {16'hA5A5, a[15:0]};
    endfunction

    assign IM = imem(PC);

    typedef struct {
        logic        stall;
        logic        flush;
        logic        br;
        logic [15:0] off;
        logic        j;
        logic [25:0] jt;
        logic        jr;
        logic [31:0] rt;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_pp1;
        logic        chk_pp1;
        logic        e_valid;
        logic        e_err;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        input logic s, input logic f, input logic b, input logic [15:0] o,
        input logic jj, input logic [25:0] t, input logic r, input logic [31:0] rv,
        input logic [31:0] epc, input logic [31:0] ein, input logic [31:0] epp,
        input logic cpp, input logic ev, input logic ee);
        vec_t v;
        v.stall = s;  v.flush = f;  v.br = b;  v.off = o;
        v.j = jj;     v.jt = t;     v.jr = r;  v.rt = rv;
        v.e_pc = epc; v.e_instr = ein; v.e_pp1 = epp;
        v.chk_pp1 = cpp; v.e_valid = ev; v.e_err = ee;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] epc, input logic [31:0] ein,
                             input logic [31:0] epp, input logic cpp, input logic ev, input logic ee);
        check({tag, ".PC"}, PC, epc);
        check({tag, ".Instr"}, IfId_Instr, ein);
        if (cpp) check({tag, ".PcPlus1"}, IfId_PcPlus1, epp);
        check({tag, ".Valid"}, {31'd0, IfId_Valid}, {31'd0, ev});
        check({tag, ".AddrErr"}, {31'd0, AddrErr}, {31'd0, ee});
    endtask

    task automatic drive_idle();
        Stall = 1'b0; Flush = 1'b0; BranchTaken = 1'b0; BranchOffset = 16'd0;
        Jump = 1'b0; JumpTarget = 26'd0; JumpReg = 1'b0; RegTarget = 32'd0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        Reset    = 1'b0;
        drive_idle();

        //          st f  br off       j  jt     jr rt            PC            Instr         PcPlus1       chk v  err
        vq.push_back(mk(0,0,0,16'h0000,0,26'd0, 0,32'd0,        32'd1,        32'h2001_0005,32'd1,        1,1,0)); // 0 first fetch
        vq.push_back(mk(0,0,0,16'h0000,0,26'd0, 0,32'd0,        32'd2,        32'hA5A5_0001,32'd2,        1,1,0));
        vq.push_back(mk(0,0,0,16'h0000,0,26'd0, 0,32'd0,        32'd3,        32'hA5A5_0002,32'd3,        1,1,0));
        vq.push_back(mk(0,0,0,16'h0000,0,26'd0, 0,32'd0,        32'd4,        32'hA5A5_0003,32'd4,        1,1,0));
        vq.push_back(mk(0,0,0,16'h0000,0,26'd0, 0,32'd0,        32'd5,        32'hA5A5_0004,32'd5,        1,1,0)); // 4 PcPlus1=5
        vq.push_back(mk(0,0,1,16'hFFFD,0,26'd0, 0,32'd0,        32'd2,        32'h0000_0000,32'd0,        1,0,0)); // 5 branch -3
        vq.push_back(mk(0,0,1,16'hFFFD,0,26'd0, 0,32'd0,        32'd3,        32'hA5A5_0002,32'd3,        1,1,0)); // 6 branch on bubble ignored
        vq.push_back(mk(0,0,0,16'h0000,0,26'd0, 0,32'd0,        32'd4,        32'hA5A5_0003,32'd4,        1,1,0));
        vq.push_back(mk(0,0,0,16'h0000,1,26'd10,1,32'd40,       32'd40,       32'h0000_0000,32'd0,        1,0,0)); // 8 JR beats J
        vq.push_back(mk(0,0,0,16'h0000,0,26'd0, 0,32'd0,        32'd41,       32'hA5A5_0028,32'd41,       1,1,0));
        vq.push_back(mk(1,0,0,16'h0000,1,26'd10,0,32'd0,        32'd10,       32'h0000_0000,32'd0,        1,0,0)); // 10 J beats stall
        vq.push_back(mk(0,0,0,16'h0000,0,26'd0, 0,32'd0,        32'd11,       32'hA5A5_000A,32'd11,       1,1,0));
        vq.push_back(mk(0,0,0,16'h0000,0,26'd0, 1,32'd6,        32'd6,        32'h0000_0000,32'd0,        1,0,0));
        vq.push_back(mk(0,0,0,16'h0000,0,26'd0, 0,32'd0,        32'd7,        32'hA5A5_0006,32'd7,        1,1,0)); // 13 at PC 7
        vq.push_back(mk(1,0,0,16'h0000,0,26'd0, 0,32'd0,        32'd7,        32'hA5A5_0006,32'd7,        1,1,0)); // 14 stall x3
        vq.push_back(mk(1,0,0,16'h0000,0,26'd0, 0,32'd0,        32'd7,        32'hA5A5_0006,32'd7,        1,1,0));
        vq.push_back(mk(1,0,0,16'h0000,0,26'd0, 0,32'd0,        32'd7,        32'hA5A5_0006,32'd7,        1,1,0));
        vq.push_back(mk(1,1,0,16'h0000,0,26'd0, 0,32'd0,        32'd7,        32'h0000_0000,32'd0,        0,0,0)); // 17 stall+flush
        vq.push_back(mk(0,1,0,16'h0000,0,26'd0, 0,32'd0,        32'd8,        32'h0000_0000,32'd0,        0,0,0)); // 18 flush alone
        vq.push_back(mk(0,0,0,16'h0000,0,26'd0, 0,32'd0,        32'd9,        32'hA5A5_0008,32'd9,        1,1,0));
        vq.push_back(mk(1,0,1,16'h0002,0,26'd0, 0,32'd0,        32'd11,       32'h0000_0000,32'd0,        1,0,0)); // 20 branch +2 over stall
        vq.push_back(mk(0,0,0,16'h0000,0,26'd0, 1,32'd99,       32'd12,       32'hA5A5_000B,32'd12,       1,1,0)); // 21 JR on bubble ignored
        vq.push_back(mk(0,0,0,16'h0000,0,26'd0, 1,32'd63,       32'd63,       32'h0000_0000,32'd0,        1,0,0)); // 22 JR 63
        vq.push_back(mk(0,0,0,16'h0000,0,26'd0, 0,32'd0,        32'd64,       32'hA5A5_003F,32'd64,       1,1,0)); // 23 fetch 63 ok
        vq.push_back(mk(0,0,0,16'h0000,0,26'd0, 0,32'd0,        32'd65,       32'hA5A5_0040,32'd65,       1,1,1)); // 24 fetch 64 err
        vq.push_back(mk(1,0,0,16'h0000,0,26'd0, 0,32'd0,        32'd65,       32'hA5A5_0040,32'd65,       1,1,1));
        vq.push_back(mk(0,0,0,16'h0000,0,26'd0, 1,32'd2,        32'd2,        32'h0000_0000,32'd0,        1,0,1)); // 26 sticky
        vq.push_back(mk(0,0,0,16'h0000,0,26'd0, 0,32'd0,        32'd3,        32'hA5A5_0002,32'd3,        1,1,1));
        vq.push_back(mk(0,0,0,16'h0000,0,26'd0, 1,32'hFFFF_FFFF,32'hFFFF_FFFF,32'h0000_0000,32'd0,        1,0,1));
        vq.push_back(mk(0,0,0,16'h0000,0,26'd0, 0,32'd0,        32'd0,        32'hA5A5_FFFF,32'd0,        1,1,1)); // 29 PC wraps
        vq.push_back(mk(0,0,0,16'h0000,0,26'd0, 1,32'h0400_0005,32'h0400_0005,32'h0000_0000,32'd0,        1,0,1));
        vq.push_back(mk(0,0,0,16'h0000,0,26'd0, 0,32'd0,        32'h0400_0006,32'hA5A5_0005,32'h0400_0006,1,1,1));
        vq.push_back(mk(0,0,0,16'h0000,1,26'd3, 0,32'd0,        32'h0400_0003,32'h0000_0000,32'd0,        1,0,1)); // 32 J keeps upper bits

        // Reset held across clock edges
        repeat (3) @(posedge Clk);
        #1;
        check_all("reset", 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        Reset = 1'b1;

        foreach (vq[i]) begin
            Stall = vq[i].stall; Flush = vq[i].flush;
            BranchTaken = vq[i].br; BranchOffset = vq[i].off;
            Jump = vq[i].j; JumpTarget = vq[i].jt;
            JumpReg = vq[i].jr; RegTarget = vq[i].rt;
            @(posedge Clk);
            #1;
            check_all($sformatf("vec%0d", i), vq[i].e_pc, vq[i].e_instr,
                      vq[i].e_pp1, vq[i].chk_pp1, vq[i].e_valid, vq[i].e_err);
        end

        // Asynchronous reset mid-cycle: outputs clear with no clock edge
        drive_idle();
        @(posedge Clk);
        #3;
        Reset = 1'b0;
        #1;
        check_all("async_rst", 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);

        // Release with a stale redirect pending: first edge fetches RESET_PC
        @(posedge Clk);
        #1;
        Reset     = 1'b1;
        JumpReg   = 1'b1;
        RegTarget = 32'd50;
        @(posedge Clk);
        #1;
        check_all("post_rst", 32'd1, 32'h2001_0005, 32'd1, 1'b1, 1'b1, 1'b0);
        drive_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fetch_unit

`default_nettype wire
